// File: rtl/input_mems_pingpong.sv
// Stream loader for the convolution engine: W/B/K shared, X double-buffered in two
// banks so the next X matrix loads while the compute core reads the current one.
module input_mems_pingpong #(
   parameter  int INW         = 24,
   parameter  int R           = 9,
   parameter  int C           = 8,
   parameter  int MAXK        = 4,
   localparam int K_BITS      = $clog2(MAXK + 1),
   localparam int X_ADDR_BITS = $clog2(R * C),
   localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic signed [INW-1:0]         AXIS_TDATA,
   input  logic                          AXIS_TVALID,
   input  logic        [K_BITS:0]        AXIS_TUSER,
   output logic                          AXIS_TREADY,
   output logic                          inputs_loaded,
   input  logic                          compute_finished,
   output logic        [K_BITS-1:0]      K,
   output logic signed [INW-1:0]         B,
   output logic                          rd_bank,
   input  logic        [X_ADDR_BITS-1:0] X_read_addr,
   output logic signed [INW-1:0]         X_data,
   input  logic        [W_ADDR_BITS-1:0] W_read_addr,
   output logic signed [INW-1:0]         W_data
);

   localparam int CNT_W = (X_ADDR_BITS > W_ADDR_BITS) ? X_ADDR_BITS : W_ADDR_BITS;
   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(R * C - 1);

   typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, LOAD_X} load_state_t;
   typedef enum logic [1:0] {EMPTY, LOADING, FULL} bank_state_t;

   load_state_t             state;
   bank_state_t             bank_st [2];
   logic                    wr_bank;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        kk_last;
   logic                    new_w;
   logic [K_BITS-1:0]       tuser_k;
   logic                    fire;
   logic                    x_we;
   logic                    w_we;
   logic [X_ADDR_BITS-1:0]  x_waddr;
   logic [W_ADDR_BITS-1:0]  w_waddr;

   logic signed [INW-1:0]   xmem0 [R*C];
   logic signed [INW-1:0]   xmem1 [R*C];
   logic signed [INW-1:0]   wmem  [MAXK*MAXK];

   function automatic logic [K_BITS-1:0] sat_k(input logic [K_BITS-1:0] k);
      if (int'(k) < 2)
         return K_BITS'(2);
      else if (int'(k) > MAXK)
         return K_BITS'(MAXK);
      else
         return k;
   endfunction

   assign new_w         = AXIS_TUSER[0];
   assign tuser_k       = AXIS_TUSER[K_BITS:1];
   assign fire          = AXIS_TVALID && AXIS_TREADY;
   assign inputs_loaded = (bank_st[rd_bank] == FULL);
   assign kk_last       = CNT_W'(int'(K) * int'(K) - 1);

   // A new_W op waits until no bank is FULL so K/B/W never change under compute.
   always_comb begin
      AXIS_TREADY = 1'b0;
      if (state == IDLE)
         AXIS_TREADY = (bank_st[wr_bank] == EMPTY) &&
                       !(AXIS_TVALID && new_w && (bank_st[0] == FULL || bank_st[1] == FULL));
      else
         AXIS_TREADY = 1'b1;
      if (reset)
         AXIS_TREADY = 1'b0;
   end

   always_comb begin
      x_we    = fire && ((state == IDLE && !new_w) || state == LOAD_X);
      w_we    = fire && ((state == IDLE && new_w) || state == LOAD_W);
      x_waddr = (state == IDLE) ? '0 : cnt[X_ADDR_BITS-1:0];
      w_waddr = (state == IDLE) ? '0 : cnt[W_ADDR_BITS-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bank_st[0] <= EMPTY;
         bank_st[1] <= EMPTY;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         cnt        <= '0;
         K          <= '0;
         B          <= '0;
      end else begin
         if (fire) begin
            unique case (state)
               IDLE: begin
                  cnt <= CNT_W'(1);
                  if (new_w) begin
                     K     <= sat_k(tuser_k);
                     state <= LOAD_W;
                  end else begin
                     bank_st[wr_bank] <= LOADING;
                     state            <= LOAD_X;
                  end
               end
               LOAD_W: begin
                  if (cnt == kk_last) begin
                     cnt   <= '0;
                     state <= LOAD_B;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               LOAD_B: begin
                  B                <= AXIS_TDATA;
                  bank_st[wr_bank] <= LOADING;
                  cnt              <= '0;
                  state            <= LOAD_X;
               end
               LOAD_X: begin
                  if (cnt == X_LAST) begin
                     bank_st[wr_bank] <= FULL;
                     wr_bank          <= ~wr_bank;
                     cnt              <= '0;
                     state            <= IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
         // The freed bank is always FULL, so it never collides with the bank being loaded.
         if (compute_finished && inputs_loaded) begin
            bank_st[rd_bank] <= EMPTY;
            rd_bank          <= ~rd_bank;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (x_we && !wr_bank)
         xmem0[x_waddr] <= AXIS_TDATA;
      if (x_we && wr_bank)
         xmem1[x_waddr] <= AXIS_TDATA;
      X_data <= rd_bank ? xmem1[X_read_addr] : xmem0[X_read_addr];
   end

   // W is single-ported: the read address owns it whenever no W word is being written.
   always_ff @(posedge clk) begin
      if (w_we)
         wmem[w_waddr] <= AXIS_TDATA;
      else
         W_data <= wmem[W_read_addr];
   end

endmodule

// File: tb/tb_input_mems_pingpong.sv
// Scoreboard bench for input_mems_pingpong: streams ops, models the banks, checks reads.
module tb_input_mems_pingpong;

   localparam int INW  = 24;
   localparam int R    = 9;
   localparam int C    = 8;
   localparam int MAXK = 4;
   localparam int KB   = 3;
   localparam int XA   = 7;
   localparam int WA   = 4;
   localparam int NX   = R * C;

   logic                  clk = 1'b0;
   logic                  reset;
   logic signed [INW-1:0] AXIS_TDATA;
   logic                  AXIS_TVALID;
   logic [KB:0]           AXIS_TUSER;
   logic                  AXIS_TREADY;
   logic                  inputs_loaded;
   logic                  compute_finished;
   logic [KB-1:0]         K;
   logic signed [INW-1:0] B;
   logic                  rd_bank;
   logic [XA-1:0]         X_read_addr;
   logic signed [INW-1:0] X_data;
   logic [WA-1:0]         W_read_addr;
   logic signed [INW-1:0] W_data;

   input_mems_pingpong #(.INW(INW), .R(R), .C(C), .MAXK(MAXK)) dut (
      .clk(clk), .reset(reset),
      .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TUSER(AXIS_TUSER),
      .AXIS_TREADY(AXIS_TREADY), .inputs_loaded(inputs_loaded),
      .compute_finished(compute_finished), .K(K), .B(B), .rd_bank(rd_bank),
      .X_read_addr(X_read_addr), .X_data(X_data),
      .W_read_addr(W_read_addr), .W_data(W_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic signed [INW-1:0] mx [2][NX];
   logic signed [INW-1:0] mw [16];
   logic signed [INW-1:0] mb;
   int                    mk;
   bit                    mwr;
   bit                    mrd;
   logic signed [INW-1:0] xq [$];
   logic signed [INW-1:0] wq [$];
   int                    cyc;

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic signed [INW-1:0] val(input int base, input int i);
      return INW'(base * 4096 + i * 97 - 3000);
   endfunction

   function automatic int satk(input int k);
      if (k < 2) return 2;
      if (k > MAXK) return MAXK;
      return k;
   endfunction

   task automatic send_word(input logic signed [INW-1:0] d, input logic [KB:0] u, inout int c);
      bit f;
      AXIS_TDATA  = d;
      AXIS_TUSER  = u;
      AXIS_TVALID = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         f = AXIS_TREADY;
         @(posedge clk);
         #1;
         c++;
         if (f) return;
      end
      check("fire_timeout", 0, 1);
   endtask

   task automatic send_op(input bit nw, input int tk, input int base, input int n_send,
                          output int c);
      int k   = satk(tk);
      int off = nw ? k * k + 1 : 0;
      int tot = off + NX;
      logic signed [INW-1:0] d;
      c = 0;
      for (int i = 0; i < n_send; i++) begin
         d = val(base, i);
         send_word(d, {KB'(tk), nw}, c);
         if (nw && i == 0) mk = k;
         if (i < off - 1) mw[i] = d;
         else if (nw && i == off - 1) mb = d;
         else mx[mwr][i - off] = d;
         if (i == tot - 1) mwr = ~mwr;
      end
      AXIS_TVALID = 1'b0;
   endtask

   task automatic rd_x(input int a0, input int n);
      for (int j = 0; j < n; j++) begin
         X_read_addr = XA'(a0 + j);
         xq.push_back(mx[mrd][a0 + j]);
         @(posedge clk);
         #1;
         check("x_data", X_data, xq.pop_front());
      end
   endtask

   task automatic rd_w(input int a0, input int n);
      for (int j = 0; j < n; j++) begin
         W_read_addr = WA'(a0 + j);
         wq.push_back(mw[a0 + j]);
         @(posedge clk);
         #1;
         check("w_data", W_data, wq.pop_front());
      end
   endtask

   task automatic pulse_cf();
      compute_finished = 1'b1;
      @(posedge clk);
      #1;
      compute_finished = 1'b0;
      mrd = ~mrd;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=%0d", total, 0);
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b1; AXIS_TDATA = '0; AXIS_TVALID = 1'b0; AXIS_TUSER = '0;
      compute_finished = 1'b0; X_read_addr = '0; W_read_addr = '0;
      mwr = 1'b0; mrd = 1'b0; mk = 0; mb = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", AXIS_TREADY, 0);
      check("rst_ld", inputs_loaded, 0);
      check("rst_k", K, 0);
      check("rst_b", B, 0);
      check("rst_rdbank", rd_bank, 0);
      reset = 1'b0;
      #1;
      check("idle_rdy", AXIS_TREADY, 1);

      // single op, K=3
      send_op(1'b1, 3, 1, 82, cyc);
      check("t1_cycles", cyc, 82);
      check("t1_ld", inputs_loaded, 1);
      check("t1_k", K, 3);
      check("t1_b", B, val(1, 9));
      check("t1_rdbank", rd_bank, 0);
      rd_x(5, 1);
      rd_x(0, 3);
      rd_x(70, 2);
      rd_w(0, 9);

      // new_W stall while bank 0 is FULL
      fork
         send_op(1'b1, 4, 2, 89, cyc);
         begin
            repeat (4) @(posedge clk);
            #2;
            check("stall_rdy", AXIS_TREADY, 0);
            check("stall_k", K, 3);
            check("stall_ld", inputs_loaded, 1);
            pulse_cf();
            check("unstall_rdy", AXIS_TREADY, 1);
            check("unstall_k", K, 3);
         end
      join
      check("t3_k", K, 4);
      check("t3_ld", inputs_loaded, 1);
      check("t3_rdbank", rd_bank, 1);
      check("t3_b", B, mb);
      rd_x(10, 3);
      rd_w(0, 16);

      // ping-pong: X-only op into the other bank
      send_op(1'b0, 0, 3, NX, cyc);
      check("pp_cycles", cyc, NX);
      check("pp_k", K, mk);
      check("pp_b", B, mb);
      check("pp_ld", inputs_loaded, 1);
      check("pp_rdbank", rd_bank, 1);
      AXIS_TVALID = 1'b1;
      AXIS_TUSER  = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("pp_full_rdy", AXIS_TREADY, 0);
      end
      AXIS_TVALID = 1'b0;
      pulse_cf();
      check("pp_sw_rdbank", rd_bank, 0);
      check("pp_sw_ld", inputs_loaded, 1);
      check("pp_sw_rdy", AXIS_TREADY, 1);
      check("pp_sw_k", K, 4);
      rd_x(20, 3);

      // last X word of bank 1 coincides with compute_finished on bank 0
      send_op(1'b0, 0, 4, NX - 1, cyc);
      AXIS_TDATA       = val(4, NX - 1);
      AXIS_TUSER       = '0;
      AXIS_TVALID      = 1'b1;
      compute_finished = 1'b1;
      @(negedge clk);
      check("sim_rdy", AXIS_TREADY, 1);
      @(posedge clk);
      #1;
      AXIS_TVALID      = 1'b0;
      compute_finished = 1'b0;
      mx[1][NX-1] = val(4, NX - 1);
      mwr = ~mwr;
      mrd = ~mrd;
      check("sim_rdbank", rd_bank, 1);
      check("sim_ld", inputs_loaded, 1);
      check("sim_rdy_after", AXIS_TREADY, 1);
      rd_x(NX - 3, 3);

      // K saturation high: 7 -> 4
      pulse_cf();
      check("sat_hi_ld0", inputs_loaded, 0);
      send_op(1'b1, 7, 5, 89, cyc);
      check("sat_hi_cycles", cyc, 89);
      check("sat_hi_k", K, 4);
      check("sat_hi_b", B, val(5, 16));
      rd_w(0, 16);
      rd_x(0, 2);

      // K saturation low: 1 -> 2
      pulse_cf();
      send_op(1'b1, 1, 6, 77, cyc);
      check("sat_lo_cycles", cyc, 77);
      check("sat_lo_k", K, 2);
      check("sat_lo_b", B, val(6, 4));
      check("sat_lo_rdbank", rd_bank, 1);
      check("sat_lo_ld", inputs_loaded, 1);
      rd_w(0, 4);
      rd_x(40, 2);

      // async reset in the middle of LOAD_X
      pulse_cf();
      send_op(1'b1, 3, 7, 40, cyc);
      AXIS_TDATA  = val(7, 40);
      AXIS_TVALID = 1'b1;
      check("mid_rdy", AXIS_TREADY, 1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_rdy", AXIS_TREADY, 0);
      check("arst_ld", inputs_loaded, 0);
      check("arst_k", K, 0);
      check("arst_b", B, 0);
      check("arst_rdbank", rd_bank, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      AXIS_TVALID = 1'b0;
      mwr = 1'b0; mrd = 1'b0; mk = 0; mb = '0;
      send_op(1'b1, 2, 8, 77, cyc);
      check("post_cycles", cyc, 77);
      check("post_k", K, 2);
      check("post_b", B, mb);
      check("post_ld", inputs_loaded, 1);
      check("post_rdbank", rd_bank, 0);
      rd_x(0, 3);
      rd_x(NX - 1, 1);
      rd_w(0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_mems_pingpong.md
Name: input_mems_pingpong

Overview:
- Next-generation input loader for the convolution engine.
- Accepts one AXI-Stream of W, B and X words and stores them in internal memories for the compute core to read.
- X storage is double-buffered: two banks alternate (ping-pong), so the next X matrix loads while the compute core reads the current one.
- W, B and K are shared by both banks. A new_W operation is held off until no X bank is pending compute, so K, B and W never change under an active computation.

Parameters:
- INW, 24, data word width (signed).
- R, 9, X rows.
- C, 8, X columns.
- MAXK, 4, maximum filter size K.
- K_BITS (local), $clog2(MAXK+1), width of K.
- X_ADDR_BITS (local), $clog2(R*C), X address width.
- W_ADDR_BITS (local), $clog2(MAXK*MAXK), W address width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- AXIS_TDATA  in  INW  stream data word.
- AXIS_TVALID  in  1  stream word valid.
- AXIS_TUSER  in  K_BITS+1  bits [K_BITS:1] = TUSER_K, bit [0] = new_W. Sampled only on the first word of an operation.
- AXIS_TREADY  out  1  loader accepts a word this cycle.
- inputs_loaded  out  1  the read bank holds a complete operation.
- compute_finished  in  1  compute core releases the read bank (1-cycle pulse).
- K  out  K_BITS  current filter size.
- B  out  INW  current bias (signed).
- rd_bank  out  1  index of the X bank currently exposed for reads.
- X_read_addr  in  X_ADDR_BITS  X read address.
- X_data  out  INW  X[rd_bank][X_read_addr], registered.
- W_read_addr  in  W_ADDR_BITS  W read address.
- W_data  out  INW  W[W_read_addr], registered.

Behaviour:
- Reset (async, active-high):
  - Both banks EMPTY, wr_bank=0, rd_bank=0, load FSM in IDLE, all counters 0.
  - K=0, B=0, AXIS_TREADY=0, inputs_loaded=0.
  - Memory contents are not cleared.
  - Reset asserted mid-load discards the partial operation.
- A word is accepted (fire) when AXIS_TVALID && AXIS_TREADY.
- Bank status: each bank is EMPTY, LOADING or FULL.
  - The load FSM writes into wr_bank.
  - The read side exposes rd_bank.
  - inputs_loaded = (bank[rd_bank] == FULL).
- Load FSM states:
  - IDLE: AXIS_TREADY=1 only if bank[wr_bank]==EMPTY and the new_W gate below passes.
    - new_W gate: if AXIS_TVALID && new_W, additionally require both banks not FULL. Until that holds, AXIS_TREADY=0 (stall).
    - On fire with new_W=1: K <= TUSER_K saturated to [2, MAXK]; write W[0]; go to LOAD_W.
    - On fire with new_W=0: write X[wr_bank][0]; bank becomes LOADING; go to LOAD_X. K, B and W are unchanged.
  - LOAD_W: AXIS_TREADY=1; each fire writes W[idx].
    - After index K*K-1, go to LOAD_B.
  - LOAD_B: one fire loads B <= AXIS_TDATA; mark bank[wr_bank] LOADING; go to LOAD_X.
  - LOAD_X: AXIS_TREADY=1; each fire writes X[wr_bank][idx] in row-major order.
    - After index R*C-1: bank[wr_bank] becomes FULL, wr_bank toggles, go to IDLE.
- Words per operation: K*K+1+R*C with new_W=1; R*C with new_W=0.
- No back-to-back bubble: while the next bank is EMPTY, IDLE accepts a word in the cycle after the last X word.
- Read side: compute_finished while inputs_loaded=1 sets bank[rd_bank] to EMPTY and toggles rd_bank on the next edge. compute_finished while inputs_loaded=0 is ignored.
- Simultaneous events:
  - If the last X word of bank b lands in the same cycle compute_finished frees bank !b, both take effect.
  - Next cycle: rd_bank=b and inputs_loaded=1.
- Read latency:
  - X_data and W_data are valid 1 cycle after the address is presented.
  - X read ports are per-bank and independent of loader writes to the other bank.
  - W writes occur only while no bank is FULL, so W_read_addr drives the W memory whenever the FSM is not in LOAD_W.
- K and B are constant whenever inputs_loaded=1.

Test Plan:
- Single op, K=3, new_W=1, 10+72 words, TVALID held 1 -> TREADY=1 for 82 cycles; then inputs_loaded=1, K=3, B equals word 10, rd_bank=0; X_read_addr=5 -> X_data=X[5] one cycle later.
- Ping-pong: op1 (K=2, new_W=1) loaded, compute not finished; op2 with new_W=0 streams 72 words -> accepted into bank 1; then TREADY=0 until compute_finished; after the pulse rd_bank=1, inputs_loaded=1, K and B unchanged.
- new_W stall: bank 0 FULL, first word with new_W=1, K=4 -> TREADY=0 until compute_finished; next cycle TREADY=1 and K updates to 4 only on fire.
- Simultaneous: last X word of bank 1 fires in the same cycle as compute_finished for bank 0 -> next cycle rd_bank=1, inputs_loaded=1, bank 0 EMPTY, TREADY=1.
- TUSER_K=7 with MAXK=4 -> K=4, 16 W words expected; TUSER_K=1 -> K=2, 4 W words expected.
- Async reset mid LOAD_X (word 30) -> immediately TREADY=0, inputs_loaded=0, K=0, B=0; after release, a fresh new_W=1 op loads correctly.
